// File: rtl/soc_irq_aggregator_if.sv
// -----------------------------------------------------------------------------
// soc_irq_aggregator_if
//   Avalon-MM slave register bus for the interrupt aggregator: 16-bit data,
//   3-bit word address, active-low write strobe, registered read data.
//   Ports (signals):
//     chipselect  master->slave  slave select
//     address     master->slave  register index [2:0]
//     write_n     master->slave  active-low write strobe
//     writedata   master->slave  write data [15:0]
//     readdata    slave->master  registered read data [15:0]
// -----------------------------------------------------------------------------
interface soc_irq_aggregator_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect, address, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_irq_aggregator.sv
// -----------------------------------------------------------------------------
// soc_irq_aggregator
//   Collects level interrupt requests from the timer and other peripherals,
//   latches them into a PENDING register (level or rising-edge per source),
//   and drives one registered combined interrupt to the CPU. A VECTOR register
//   names the highest-priority active source (bit 0 = timer = highest).
//   Ports:
//     clk      system clock
//     reset_n  asynchronous, active-low reset
//     bus      register slave (chipselect/address/write_n/writedata/readdata)
//     irq_in   [NUM_IRQ-1:0] peripheral requests, level, may be asynchronous
//     irq_out  combined interrupt, registered, active-high
//   Register map: 0 STATUS, 1 PENDING (W1C), 2 MASK, 3 MODE (1 = edge),
//                 4 ACTIVE, 5 VECTOR, 6 FORCE (WO), 7 reserved.
// -----------------------------------------------------------------------------
module soc_irq_aggregator #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    soc_irq_aggregator_if.slave bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                irq_out
);
    // Per-source registers are held 16 bits wide so they drop straight onto
    // the bus; bits above NUM_IRQ are forced to zero by this mask.
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_MODE    = 3'd3;
    localparam logic [2:0] A_ACTIVE  = 3'd4;
    localparam logic [2:0] A_VECTOR  = 3'd5;
    localparam logic [2:0] A_FORCE   = 3'd6;

    // Synchroniser chain: [0] samples irq_in, [SYNC_STAGES-1] is the output.
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [15:0] r_sync_d;
    logic [15:0] r_pending;
    logic [15:0] r_mask;
    logic [15:0] r_mode;
    logic [15:0] r_readdata;
    logic        r_irq_out;

    logic        w_wr;
    logic [15:0] w_wdata;
    logic [15:0] w_sync;
    logic [15:0] w_rise;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_active;
    logic        w_vec_valid;
    logic [3:0]  w_vec_idx;
    logic [15:0] w_rdata;

    assign w_wr    = bus.chipselect && !bus.write_n;
    assign w_wdata = bus.writedata & SRC_MASK;
    assign w_sync  = 16'(r_sync[SYNC_STAGES-1]);
    assign w_rise  = w_sync & ~r_sync_d;

    // Hardware set (level or edge per MODE) plus software FORCE.
    assign w_set = (r_mode & w_rise) | (~r_mode & w_sync)
                 | ((w_wr && bus.address == A_FORCE) ? w_wdata : 16'h0000);
    assign w_clr = (w_wr && bus.address == A_PENDING) ? w_wdata : 16'h0000;

    assign w_active    = r_pending & r_mask;
    assign w_vec_valid = |w_active;

    // Lowest set ACTIVE bit wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_vec_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) w_vec_idx = 4'(i);
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (bus.address)
            A_STATUS:  w_rdata = w_sync;
            A_PENDING: w_rdata = r_pending;
            A_MASK:    w_rdata = r_mask;
            A_MODE:    w_rdata = r_mode;
            A_ACTIVE:  w_rdata = w_active;
            A_VECTOR:  w_rdata = w_vec_valid ? {1'b1, 11'd0, w_vec_idx} : 16'h0000;
            default:   w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_sync_d <= w_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_readdata <= '0;
            r_irq_out  <= 1'b0;
        end else begin
            // Set is OR'd after the clear so a same-cycle set always survives.
            r_pending  <= (r_pending & ~w_clr) | w_set;
            r_readdata <= w_rdata;
            r_irq_out  <= |w_active;
            if (w_wr && bus.address == A_MASK) r_mask <= w_wdata;
            if (w_wr && bus.address == A_MODE) r_mode <= w_wdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq_out      = r_irq_out;

endmodule

// File: tb/tb_soc_irq_aggregator.sv
module tb_soc_irq_aggregator;
    localparam int NUM_IRQ = 8;
    localparam int SS      = 2;
    localparam logic [15:0] SRC = 16'h00FF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic irq_out;

    int n_chk = 0;
    int n_fail = 0;

    soc_irq_aggregator_if bif ();

    soc_irq_aggregator #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // sync is simply "irq_in as sampled SS edges ago" (0 if not that many
    // edges since reset); previous sync is one edge further back.
    logic [15:0] m_samp [0:1023];
    int          m_cyc;
    logic [15:0] m_pend, m_mask, m_mode, m_rd;
    logic        m_irq;

    function automatic logic [15:0] sample_back(input int back);
        if (m_cyc >= back) return m_samp[(m_cyc - back) % 1024];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] vec_of(input logic [15:0] act);
        for (int i = 0; i < 16; i++)
            if (act[i]) return 16'h8000 | 16'(i);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return sample_back(SS);
            3'd1: return m_pend;
            3'd2: return m_mask;
            3'd3: return m_mode;
            3'd4: return m_pend & m_mask;
            3'd5: return vec_of(m_pend & m_mask);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] model_next_pend();
        logic [15:0] s, sd, hw, sw_set, sw_clr;
        logic wr;
        s  = sample_back(SS);
        sd = sample_back(SS + 1);
        wr = bif.chipselect && !bif.write_n;
        hw = 16'h0000;
        for (int i = 0; i < 16; i++)
            hw[i] = m_mode[i] ? (s[i] && !sd[i]) : s[i];
        sw_set = (wr && bif.address == 3'd6) ? (bif.writedata & SRC) : 16'h0000;
        sw_clr = (wr && bif.address == 3'd1) ? (bif.writedata & SRC) : 16'h0000;
        return (m_pend & ~sw_clr) | hw | sw_set;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc  <= 0;
            m_pend <= '0;
            m_mask <= '0;
            m_mode <= '0;
            m_rd   <= '0;
            m_irq  <= 1'b0;
        end else begin
            m_rd   <= model_read(bif.address);
            m_irq  <= |(m_pend & m_mask);
            m_pend <= model_next_pend();
            if (bif.chipselect && !bif.write_n && bif.address == 3'd2) m_mask <= bif.writedata & SRC;
            if (bif.chipselect && !bif.write_n && bif.address == 3'd3) m_mode <= bif.writedata & SRC;
            m_samp[m_cyc % 1024] <= 16'(irq_in);
            m_cyc <= m_cyc + 1;
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            n_chk++;
            if (irq_out !== m_irq) begin
                n_fail++;
                $display("FAIL model_irq_out t=%0t got %b exp %b", $time, irq_out, m_irq);
            end
            n_chk++;
            if (bif.readdata !== m_rd) begin
                n_fail++;
                $display("FAIL model_readdata t=%0t got %h exp %h", $time, bif.readdata, m_rd);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bif.chipselect = 1'b1;
        bif.address    = a;
        bif.write_n    = 1'b0;
        bif.writedata  = d;
        @(negedge clk);
        bif.chipselect = 1'b0;
        bif.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bif.chipselect = 1'b1;
        bif.address    = a;
        bif.write_n    = 1'b1;
        @(negedge clk);
        d = bif.readdata;
        bif.chipselect = 1'b0;
    endtask

    logic [15:0] v;

    initial begin
        bif.chipselect = 1'b0;
        bif.address    = 3'd0;
        bif.write_n    = 1'b1;
        bif.writedata  = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("reset_read_%0d", a), v, 16'h0000);
        end
        chk("reset_irq_out", 16'(irq_out), 16'h0000);

        // Level, timer path
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) chk("lvl_irq_out_3edges", 16'(irq_out), 16'h0000);
            if (k == 4) chk("lvl_irq_out_4edges", 16'(irq_out), 16'h0001);
        end
        rd(3'd0, v); chk("lvl_status", v, 16'h0001);
        rd(3'd1, v); chk("lvl_pending", v, 16'h0001);
        rd(3'd5, v); chk("lvl_vector", v, 16'h8000);
        wr(3'd1, 16'h0001);
        chk("lvl_w1c_high_irq", 16'(irq_out), 16'h0001);
        rd(3'd1, v); chk("lvl_w1c_high_pend", v, 16'h0001);
        irq_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd1, v); chk("lvl_latched", v, 16'h0001);
        wr(3'd1, 16'h0001);
        chk("lvl_clr_irq_same", 16'(irq_out), 16'h0001);
        @(negedge clk);
        chk("lvl_clr_irq_next", 16'(irq_out), 16'h0000);

        // Edge mode
        wr(3'd3, 16'h0004);
        wr(3'd2, 16'h0004);
        irq_in[2] = 1'b1;
        repeat (20) @(negedge clk);
        rd(3'd1, v); chk("edge_pending", v, 16'h0004);
        wr(3'd1, 16'h0004);
        repeat (3) @(negedge clk);
        rd(3'd1, v); chk("edge_no_reset", v, 16'h0000);
        chk("edge_irq_low", 16'(irq_out), 16'h0000);
        irq_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        irq_in[2] = 1'b1;
        repeat (5) @(negedge clk);
        rd(3'd1, v); chk("edge_second", v, 16'h0004);

        // Priority and mask
        irq_in[2] = 1'b0;
        wr(3'd1, 16'h00FF);
        wr(3'd2, 16'h00FF);
        wr(3'd6, 16'h0048);
        rd(3'd1, v); chk("pri_pending", v, 16'h0048);
        rd(3'd5, v); chk("pri_vector3", v, 16'h8003);
        rd(3'd4, v); chk("pri_active", v, 16'h0048);
        rd(3'd6, v); chk("pri_force_reads0", v, 16'h0000);
        wr(3'd1, 16'h0008);
        rd(3'd5, v); chk("pri_vector6", v, 16'h8006);
        wr(3'd2, 16'h0000);
        @(negedge clk);
        chk("pri_masked_irq", 16'(irq_out), 16'h0000);
        rd(3'd1, v); chk("pri_masked_pend", v, 16'h0040);
        rd(3'd5, v); chk("pri_masked_vec", v, 16'h0000);
        wr(3'd3, 16'hFF14);
        rd(3'd3, v); chk("mode_upper_ignored", v, 16'h0014);

        // Edge lands in the same cycle as W1C of that bit: set wins
        @(negedge clk);
        irq_in[4] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bif.chipselect = 1'b1; bif.address = 3'd1; bif.write_n = 1'b0; bif.writedata = 16'h0010;
        @(negedge clk);
        bif.chipselect = 1'b0; bif.write_n = 1'b1;
        rd(3'd1, v); chk("setclr_pending", v, 16'h0050);

        // Async reset mid-operation
        irq_in = 8'h02;
        wr(3'd6, 16'h00FF);
        wr(3'd2, 16'h00FF);
        rd(3'd1, v); chk("rst_pre_pending", v, 16'h00FF);
        @(negedge clk);
        chk("rst_pre_irq", 16'(irq_out), 16'h0001);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_irq", 16'(irq_out), 16'h0000);
        chk("rst_async_rdata", bif.readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        bif.chipselect = 1'b1; bif.address = 3'd2; bif.write_n = 1'b0; bif.writedata = 16'h0002;
        @(negedge clk);
        bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.address = 3'd1;
        @(negedge clk);
        chk("rst_pend_cleared", bif.readdata, 16'h0000);
        @(negedge clk);
        chk("rst_irq_3edges", 16'(irq_out), 16'h0000);
        @(negedge clk);
        chk("rst_irq_4edges", 16'(irq_out), 16'h0001);
        chk("rst_relatch", bif.readdata, 16'h0002);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/soc_irq_aggregator.md
Name: soc_irq_aggregator

Overview:
Avalon-MM slave interrupt aggregator that consumes the level `irq` outputs of the SoC timer and other peripherals. It presents one combined, registered interrupt to the Nios II CPU, plus a vector register naming the highest-priority source. The timer's `irq` is wired to `irq_in[0]`, so it has the highest priority. Register access uses the same 16-bit, 3-bit-address, registered-readdata slave style as the timer.

Parameters:
NUM_IRQ, 8, number of interrupt inputs; legal range 1..16.
SYNC_STAGES, 2, flip-flops in each `irq_in` synchroniser chain; minimum 2.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
chipselect  input  1  slave select
address  input  3  register index
write_n  input  1  active-low write strobe
writedata  input  16  write data
readdata  output  16  registered read data
irq_in  input  NUM_IRQ  peripheral interrupt requests; level, active-high, may be asynchronous
irq_out  output  1  combined interrupt to the CPU; registered, active-high

Behaviour:
- Reset: `clk` only; reset `reset_n` is asynchronous, active-low.
- Reset values: all registers, synchroniser chains and edge history = 0; `readdata` = 0; `irq_out` = 0.
- Write strobe: `wr = chipselect && !write_n`.
- Read path: `readdata` is registered from a mux on `address` every cycle, regardless of `chipselect`. It reflects register state before any same-cycle write.
- Unused bits: bits [15:NUM_IRQ] of every per-source register read 0. Writes to those bits are ignored.
- Register map:
  - 0 STATUS (RO): synchronised `irq_in` levels (`sync`).
  - 1 PENDING (R/W1C): latched requests; writing 1 clears the bit.
  - 2 MASK (RW): per-source enable; reset 0.
  - 3 MODE (RW): per-source mode; 0 = level, 1 = rising-edge.
  - 4 ACTIVE (RO): PENDING & MASK.
  - 5 VECTOR (RO): bit15 = valid (ACTIVE != 0); bits[3:0] = index of lowest set ACTIVE bit (0 = highest priority); bits[14:4] = 0. When not valid, the whole register reads 0.
  - 6 FORCE (WO): writing 1 sets the PENDING bit (software trigger); reads 0.
  - 7 reserved: reads 0; writes ignored.
- Synchroniser: `irq_in[i]` passes through SYNC_STAGES flops to give `sync[i]`. A history flop `sync_d[i]` holds the previous `sync[i]`.
- Set condition for PENDING[i]:
  - `set[i] = (MODE[i] ? (sync[i] & ~sync_d[i]) : sync[i]) | (wr && address==6 && writedata[i])`.
- Clear condition for PENDING[i]:
  - `clr[i] = wr && address==1 && writedata[i]`.
- PENDING update rules:
  - Set wins over clear in the same cycle.
  - A level-mode source that is still high re-sets its bit on the next cycle after a W1C.
- `irq_out` is registered: `irq_out <= |(PENDING & MASK)`, updated every cycle.
- Latency (SYNC_STAGES=2), counted from the first clk edge that samples `irq_in` high:
  - STATUS bit set after 2 edges.
  - PENDING set after 3 edges.
  - `irq_out` high after 4 edges.
  - In general: SYNC_STAGES + 2 edges.
- Mask change: a MASK write takes effect on `irq_out` one cycle after the write edge. Masked sources still latch into PENDING.
- MODE change: changing MODE does not clear PENDING or the edge history. An edge is detected only on a 0→1 transition of `sync` while MODE = 1.
- Reset mid-operation: all state clears, including `sync_d`.
  - An input held high through reset in edge mode is seen as a fresh rising edge once synchronised.
  - In level mode it simply re-latches.
- Pulse width: `irq_in` pulses shorter than one clk period may be missed. The timer's level `irq` is unaffected by this.

Test Plan:
- Reset, then read addresses 0..7 → all read 0x0000; `irq_out` = 0.
- Level, timer path: MASK=0x0001, MODE=0; raise `irq_in[0]` at edge N → STATUS=0x0001 at N+2, PENDING=0x0001 at N+3, `irq_out`=1 at N+4, VECTOR=0x8000. Then write PENDING=0x0001 while the input is still high → bit re-sets the next cycle and `irq_out` stays 1. Drop the input, write PENDING=0x0001 → `irq_out`=0 one cycle later.
- Edge: MODE=0x0004, MASK=0x0004; hold `irq_in[2]` high for 20 cycles → PENDING=0x0004 is set exactly once. W1C 0x0004 → PENDING stays 0 while the input remains high; a second rising edge sets it again.
- Priority and mask: MASK=0x00FF; FORCE write 0x0048 → PENDING=0x0048, VECTOR=0x8003. W1C 0x0008 → VECTOR=0x8006. MASK=0x0000 → `irq_out`=0, while PENDING still reads 0x0040.
- Simultaneous set/clear: in the same cycle a FORCE write of 0x0010 and a W1C of 0x0010 cannot coincide, so instead pulse edge-mode `irq_in[4]` so its edge lands in the cycle of the W1C 0x0010 → PENDING[4] = 1.
- Async reset mid-operation: with PENDING=0x00FF and `irq_out`=1, assert `reset_n` between clock edges → `irq_out`, PENDING and `readdata` go 0 immediately. Release with `irq_in[1]` high, MODE=0, MASK=0x0002 written → PENDING[1] re-latches 3 edges after release.
